// File: rtl/serial_adder_sub.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry flop,
// one operand bit per clock, LSB first, with start/ready/done handshake.
module serial_adder_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic             s, c;

  assign s = opa_q[0] ^ opb_q[0] ^ carry_q;
  assign c = (opa_q[0] & opb_q[0]) |
             (opa_q[0] & carry_q) |
             (opb_q[0] & carry_q);

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          opa_d   = a;
          opb_d   = sub ? ~b : b;
          carry_d = sub;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        carry_d = c;
        opa_d   = {1'b0, opa_q[WIDTH-1:1]};
        opb_d   = {1'b0, opb_q[WIDTH-1:1]};
        res_d   = {s, res_q[WIDTH-1:1]};
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          // carry_q here is the carry into the MSB
          sum_d   = {s, res_q[WIDTH-1:1]};
          cout_d  = c;
          ovf_d   = carry_q ^ c;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign ready    = (state_q == IDLE);
  assign done     = done_q;
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder_sub.sv
// Directed bench for serial_adder_sub at WIDTH=8 and WIDTH=16.
// Cycle 1 is the cycle that begins at the start-accept edge.
module tb_serial_adder_sub;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start8 = 1'b0;
  logic        sub8 = 1'b0;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic        rdy8, done8, cout8, ovf8;
  logic [7:0]  sum8;

  logic        start16 = 1'b0;
  logic        sub16 = 1'b0;
  logic [15:0] a16 = '0;
  logic [15:0] b16 = '0;
  logic        rdy16, done16, cout16, ovf16;
  logic [15:0] sum16;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  serial_adder_sub #(.WIDTH(8)) u8 (
    .clk      (clk),
    .rst      (rst),
    .start    (start8),
    .sub      (sub8),
    .a        (a8),
    .b        (b8),
    .ready    (rdy8),
    .done     (done8),
    .sum      (sum8),
    .cout     (cout8),
    .overflow (ovf8)
  );

  serial_adder_sub #(.WIDTH(16)) u16 (
    .clk      (clk),
    .rst      (rst),
    .start    (start16),
    .sub      (sub16),
    .a        (a16),
    .b        (b16),
    .ready    (rdy16),
    .done     (done16),
    .sum      (sum16),
    .cout     (cout16),
    .overflow (ovf16)
  );

  // Launches one 8-bit op and returns in its done cycle.
  task automatic run_op8(
    input  logic [7:0] ia,
    input  logic [7:0] ib,
    input  logic       isub,
    output int         lat,
    output int         rlow
  );
    int w;
    w = 0;
    while (!rdy8 && w < 50) begin
      @(posedge clk); #1; w++;
    end
    start8 = 1'b1; a8 = ia; b8 = ib; sub8 = isub;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 1; rlow = 0;
    while (!done8 && lat < 40) begin
      if (!rdy8) rlow++;
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    nvec++;
    if ({rdy8, done8, sum8, cout8, ovf8} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      nerr++;
      $display("FAIL reset8: got rdy=%b done=%b sum=%h c=%b v=%b want 1 0 00 0 0",
               rdy8, done8, sum8, cout8, ovf8);
    end
    nvec++;
    if ({rdy16, done16, sum16, cout16, ovf16} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0}) begin
      nerr++;
      $display("FAIL reset16: got rdy=%b done=%b sum=%h c=%b v=%b want 1 0 0000 0 0",
               rdy16, done16, sum16, cout16, ovf16);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_add;
    int lat, rlow;
    run_op8(8'h5A, 8'h3C, 1'b0, lat, rlow);
    nvec++;
    if (lat !== 9) begin
      nerr++; $display("FAIL add_latency: got %0d want 9", lat);
    end
    nvec++;
    if (rlow !== 8) begin
      nerr++; $display("FAIL add_ready_low: got %0d want 8", rlow);
    end
    nvec++;
    if ({sum8, cout8, ovf8} !== {8'h96, 1'b0, 1'b1}) begin
      nerr++;
      $display("FAIL add_5A_3C: got %h c=%b v=%b want 96 0 1", sum8, cout8, ovf8);
    end
    @(posedge clk); #1;
    nvec++;
    if (done8 !== 1'b0) begin
      nerr++; $display("FAIL done_pulse_width: got %b want 0", done8);
    end
    run_op8(8'hFF, 8'h01, 1'b0, lat, rlow);
    nvec++;
    if ({sum8, cout8, ovf8} !== {8'h00, 1'b1, 1'b0}) begin
      nerr++;
      $display("FAIL add_FF_01: got %h c=%b v=%b want 00 1 0", sum8, cout8, ovf8);
    end
    run_op8(8'h7F, 8'h01, 1'b0, lat, rlow);
    nvec++;
    if ({sum8, cout8, ovf8} !== {8'h80, 1'b0, 1'b1}) begin
      nerr++;
      $display("FAIL add_7F_01: got %h c=%b v=%b want 80 0 1", sum8, cout8, ovf8);
    end
  endtask

  task automatic test_sub;
    int lat, rlow;
    run_op8(8'h10, 8'h20, 1'b1, lat, rlow);
    nvec++;
    if ({sum8, cout8, ovf8} !== {8'hF0, 1'b0, 1'b0}) begin
      nerr++;
      $display("FAIL sub_10_20: got %h c=%b v=%b want F0 0 0", sum8, cout8, ovf8);
    end
    run_op8(8'h80, 8'h01, 1'b1, lat, rlow);
    nvec++;
    if ({sum8, cout8, ovf8} !== {8'h7F, 1'b1, 1'b1}) begin
      nerr++;
      $display("FAIL sub_80_01: got %h c=%b v=%b want 7F 1 1", sum8, cout8, ovf8);
    end
    run_op8(8'h33, 8'h33, 1'b1, lat, rlow);
    nvec++;
    if ({sum8, cout8, ovf8} !== {8'h00, 1'b1, 1'b0}) begin
      nerr++;
      $display("FAIL sub_33_33: got %h c=%b v=%b want 00 1 0", sum8, cout8, ovf8);
    end
  endtask

  task automatic test_busy_ignore;
    int cyc;
    @(posedge clk); #1;
    start8 = 1'b1; a8 = 8'h12; b8 = 8'h34; sub8 = 1'b0;
    @(posedge clk); #1;
    cyc = 1;
    while (!done8 && cyc < 40) begin
      start8 = cyc[0];
      a8 = ~a8; b8 = b8 + 8'h11; sub8 = ~sub8;
      @(posedge clk); #1; cyc++;
    end
    start8 = 1'b0;
    nvec++;
    if (cyc !== 9) begin
      nerr++; $display("FAIL busy_latency: got %0d want 9", cyc);
    end
    nvec++;
    if ({sum8, cout8, ovf8} !== {8'h46, 1'b0, 1'b0}) begin
      nerr++;
      $display("FAIL busy_ignore: got %h c=%b v=%b want 46 0 0", sum8, cout8, ovf8);
    end
  endtask

  task automatic test_back_to_back;
    int lat, rlow;
    @(posedge clk); #1;
    run_op8(8'h01, 8'h02, 1'b0, lat, rlow);
    nvec++;
    if (sum8 !== 8'h03) begin
      nerr++; $display("FAIL b2b_first: got %h want 03", sum8);
    end
    nvec++;
    if ({rdy8, done8} !== 2'b11) begin
      nerr++; $display("FAIL b2b_rdy_done: got %b want 11", {rdy8, done8});
    end
    run_op8(8'h04, 8'h08, 1'b0, lat, rlow);
    nvec++;
    if (lat !== 9) begin
      nerr++; $display("FAIL b2b_spacing: got %0d want 9", lat);
    end
    nvec++;
    if (sum8 !== 8'h0C) begin
      nerr++; $display("FAIL b2b_second: got %h want 0C", sum8);
    end
  endtask

  task automatic test_reset_mid;
    int lat, rlow, seen;
    run_op8(8'h80, 8'h01, 1'b1, lat, rlow);
    @(posedge clk); #1;
    start8 = 1'b1; a8 = 8'h0F; b8 = 8'h01; sub8 = 1'b0;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    nvec++;
    if ({rdy8, done8, sum8, cout8, ovf8} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      nerr++;
      $display("FAIL mid_reset: got rdy=%b done=%b sum=%h c=%b v=%b want 1 0 00 0 0",
               rdy8, done8, sum8, cout8, ovf8);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done8) seen++;
    end
    nvec++;
    if (seen !== 0) begin
      nerr++; $display("FAIL no_done_after_abort: got %0d pulses want 0", seen);
    end
    run_op8(8'h11, 8'h22, 1'b0, lat, rlow);
    nvec++;
    if (lat !== 9 || sum8 !== 8'h33) begin
      nerr++; $display("FAIL post_reset_op: got lat=%0d sum=%h want 9 33", lat, sum8);
    end
  endtask

  task automatic test_width16;
    int cyc;
    @(posedge clk); #1;
    start16 = 1'b1; a16 = 16'hFFFF; b16 = 16'hFFFF; sub16 = 1'b0;
    @(posedge clk); #1;
    start16 = 1'b0;
    cyc = 1;
    while (!done16 && cyc < 60) begin
      @(posedge clk); #1; cyc++;
    end
    nvec++;
    if (cyc !== 17) begin
      nerr++; $display("FAIL w16_latency: got %0d want 17", cyc);
    end
    nvec++;
    if ({sum16, cout16, ovf16} !== {16'hFFFE, 1'b1, 1'b0}) begin
      nerr++;
      $display("FAIL w16_add: got %h c=%b v=%b want FFFE 1 0", sum16, cout16, ovf16);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_width16();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/serial_adder_sub.md
Name: serial_adder_sub

Overview:
- Parametrised bit-serial adder/subtractor: one full-adder cell plus a registered carry, processing one operand bit per clock, LSB first.
- Replaces wide combinational adders in area-constrained datapaths where WIDTH cycles of latency are acceptable.
- start/ready/done handshake; registered result with unsigned carry-out and signed overflow flags.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; accepted only when ready=1
- sub  input  1  mode, sampled with start: 0 = a+b, 1 = a-b
- a  input  WIDTH  operand A, sampled with start
- b  input  WIDTH  operand B, sampled with start
- ready  output  1  block idle; a start will be accepted
- done  output  1  one-cycle pulse; result valid and newly updated
- sum  output  WIDTH  result; held until the next completion
- cout  output  1  carry out of MSB; for sub, 1 = no borrow
- overflow  output  1  signed two's-complement overflow

Behaviour:
- Reset (async assert, deasserted synchronously by the environment):
  - ready=1, done=0, sum=0, cout=0, overflow=0.
  - Internal shift registers, carry and bit counter are cleared; FSM goes to IDLE.
- FSM states: IDLE, BUSY.
- IDLE:
  - ready=1.
  - On an edge with start=1, capture opA=a and opB=(sub ? ~b : b). Set carry=sub, cnt=0, go to BUSY. ready drops to 0 after that edge.
- BUSY, each edge:
  - s = opA[0]^opB[0]^carry.
  - carry <= majority(opA[0], opB[0], carry).
  - opA and opB shift right by 1.
  - s shifts into the MSB of the internal result register.
  - cnt <= cnt+1.
- Completion, on the edge processing bit WIDTH-1 (cnt==WIDTH-1):
  - Load sum with the completed result, including the bit processed on this edge.
  - cout <= final carry.
  - overflow <= carry into MSB XOR carry out of MSB. The carry into MSB is the carry register value before this edge.
  - done <= 1; return to IDLE (ready <= 1).
- Latency:
  - start accepted at edge E0.
  - Bits are processed at edges E1..E_WIDTH.
  - done=1 during the cycle after E_WIDTH and is 0 otherwise.
  - Throughput is one operation per WIDTH+1 cycles.
- Back-to-back:
  - ready and done are high in the same cycle.
  - A start in that cycle is accepted, so the next operation begins without an idle gap.
  - sum/cout/overflow keep the previous result until the next completion.
- start while BUSY is ignored. Operands and mode are not re-sampled; a, b and sub may change freely during BUSY.
- sum, cout and overflow change only at completion edges or on reset.
- Reset mid-operation aborts immediately. No done pulse is produced, all outputs return to their reset values, and the block accepts a new start on the first edge after rst deasserts.
- Arithmetic is modulo 2^WIDTH; no saturation.
- cnt width is clog2(WIDTH)+1 bits, so there is no wrap ambiguity at WIDTH=32.

Test Plan:
- WIDTH=8, add 0x5A+0x3C:
  - done exactly 9 cycles after the start-accept edge, for 1 cycle.
  - sum=0x96, cout=0, overflow=1.
  - ready low for 8 cycles.
- Add 0xFF+0x01 -> sum=0x00, cout=1, overflow=0. Add 0x7F+0x01 -> sum=0x80, cout=0, overflow=1.
- Sub 0x10-0x20 -> sum=0xF0, cout=0, overflow=0. Sub 0x80-0x01 -> sum=0x7F, cout=1, overflow=1. Sub 0x33-0x33 -> sum=0x00, cout=1.
- Start pulses and operand/sub changes during BUSY:
  - Ignored; the result matches the originally captured operands.
  - Start asserted in the done cycle launches the second op: 0x01+0x02 then 0x04+0x08 give 0x03 then 0x0C, with done pulses 9 cycles apart.
- Assert rst at cycle 4 of an operation:
  - All outputs return to reset values asynchronously; no done pulse follows.
  - After release, 0x11+0x22 -> 0x33 with normal latency.
- WIDTH=16, add 0xFFFF+0xFFFF:
  - sum=0xFFFE, cout=1, overflow=0.
  - done 17 cycles after accept.
